// File: rtl/exponent_core.sv
// exponent_core: sequential unsigned integer exponentiation by repeated squaring.
// Computes p_out = x_in ** a_in mod 2**P_WIDTH. The right-to-left binary method
// is used: one exponent bit is consumed per CALC cycle. A single FIN cycle then
// raises done, which stays high until the next accepted start or a reset.
// Optional build macro: EXPONENT_OVERFLOW_EN adds the overflow output. This
// output is set when the true mathematical result does not fit in P_WIDTH bits.
module exponent_core #(
    parameter int X_WIDTH = 8,
    parameter int A_WIDTH = 4,
    parameter int P_WIDTH = 15
) (
    input  logic               S_AXI_ACLK,
    input  logic               S_AXI_ARESET,
    input  logic               start,
    input  logic [X_WIDTH-1:0] x_in,
    input  logic [A_WIDTH-1:0] a_in,
    output logic               busy,
    output logic               done,
    output logic [P_WIDTH-1:0] p_out
`ifdef EXPONENT_OVERFLOW_EN
    ,
    output logic               overflow
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [P_WIDTH-1:0] base_q, base_d;
    logic [A_WIDTH-1:0] exp_q, exp_d;
    logic [P_WIDTH-1:0] acc_q, acc_d;
    logic [P_WIDTH-1:0] p_out_q, p_out_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Truncated products that are used by the datapath.
    logic [P_WIDTH-1:0] sq_lo;
    logic [P_WIDTH-1:0] mul_lo;

`ifdef EXPONENT_OVERFLOW_EN
    logic                 base_ovf_q, base_ovf_d;
    logic                 ovf_q, ovf_d;
    logic [2*P_WIDTH-1:0] sq_full;
    logic [2*P_WIDTH-1:0] mul_full;
    logic                 sq_trunc;
    logic                 mul_trunc;

    // Full-width products: the upper halves show when truncation happened.
    always_comb begin
        sq_full   = (2*P_WIDTH)'(base_q) * (2*P_WIDTH)'(base_q);
        mul_full  = (2*P_WIDTH)'(acc_q) * (2*P_WIDTH)'(base_q);
        sq_lo     = sq_full[P_WIDTH-1:0];
        mul_lo    = mul_full[P_WIDTH-1:0];
        sq_trunc  = |sq_full[2*P_WIDTH-1:P_WIDTH];
        mul_trunc = |mul_full[2*P_WIDTH-1:P_WIDTH];
    end
`else
    // Only the low P_WIDTH bits of each product are ever needed.
    always_comb begin
        sq_lo  = base_q * base_q;
        mul_lo = acc_q * base_q;
    end
`endif

    // Next-state and datapath logic for the IDLE -> CALC -> FIN sequence.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        exp_d   = exp_q;
        acc_d   = acc_q;
        p_out_d = p_out_q;
        busy_d  = busy_q;
        done_d  = done_q;
`ifdef EXPONENT_OVERFLOW_EN
        base_ovf_d = base_ovf_q;
        ovf_d      = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                // busy is low throughout IDLE, so start is only acted on here.
                if (start) begin
                    base_d  = P_WIDTH'(x_in);
                    exp_d   = a_in;
                    acc_d   = P_WIDTH'(1);
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    state_d = CALC;
`ifdef EXPONENT_OVERFLOW_EN
                    base_ovf_d = 1'b0;
                    ovf_d      = 1'b0;
`endif
                end
            end
            CALC: begin
                if (exp_q != '0) begin
                    if (exp_q[0]) begin
                        acc_d = mul_lo;
`ifdef EXPONENT_OVERFLOW_EN
                        // A truncated base is already >= 2**P_WIDTH, so any
                        // multiply that uses it has overflowed as well.
                        if (mul_trunc || base_ovf_q) begin
                            ovf_d = 1'b1;
                        end
`endif
                    end
                    base_d = sq_lo;
                    exp_d  = exp_q >> 1;
`ifdef EXPONENT_OVERFLOW_EN
                    // The flag only matters if a later acc multiply uses this base.
                    if (sq_trunc) begin
                        base_ovf_d = 1'b1;
                    end
`endif
                end else begin
                    p_out_d = acc_q;
                    state_d = FIN;
                end
            end
            FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset discards any in-flight computation.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            state_q <= IDLE;
            base_q  <= '0;
            exp_q   <= '0;
            acc_q   <= '0;
            p_out_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef EXPONENT_OVERFLOW_EN
            base_ovf_q <= 1'b0;
            ovf_q      <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            exp_q   <= exp_d;
            acc_q   <= acc_d;
            p_out_q <= p_out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef EXPONENT_OVERFLOW_EN
            base_ovf_q <= base_ovf_d;
            ovf_q      <= ovf_d;
`endif
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign p_out = p_out_q;
`ifdef EXPONENT_OVERFLOW_EN
    assign overflow = ovf_q;
`endif

endmodule

// File: tb/tb_exponent_core.sv
// tb_exponent_core: directed vectors with a scoreboard queue. Stimulus pushes
// the hand-computed result, and a monitor pops and compares it on each rising edge of done.
module tb_exponent_core;

    logic        clk;
    logic        srst;
    logic        start;
    logic [7:0]  x_in;
    logic [3:0]  a_in;
    logic        busy;
    logic        done;
    logic [14:0] p_out;
`ifdef EXPONENT_OVERFLOW_EN
    logic        overflow;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [14:0] p;
        logic        ovf;
        string       name;
    } exp_t;

    exp_t sb_q[$];

    exponent_core #(
        .X_WIDTH(8),
        .A_WIDTH(4),
        .P_WIDTH(15)
    ) dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESET (srst),
        .start        (start),
        .x_in         (x_in),
        .a_in         (a_in),
        .busy         (busy),
        .done         (done),
        .p_out        (p_out)
`ifdef EXPONENT_OVERFLOW_EN
        ,
        .overflow     (overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, req);
        end
    endtask

    // Monitor: compare each completed result against the oldest expectation.
    logic done_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (done && !done_prev) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual p_out=%0d expected no result", p_out);
            end else begin
                e = sb_q.pop_front();
                chk({e.name, "_p_out"}, 32'(p_out), 32'(e.p));
`ifdef EXPONENT_OVERFLOW_EN
                chk({e.name, "_overflow"}, 32'(overflow), 32'(e.ovf));
`endif
                $display("result %s p_out=%0d", e.name, p_out);
            end
        end
        done_prev = done;
    end

    // Drive start for exactly one edge (E0); returns at the negedge after E0.
    // After capture, the inputs are scrambled: only the capture edge may matter.
    task automatic issue(input logic [7:0] x, input logic [3:0] a, input logic push,
                         input logic [14:0] p, input logic o, input string nm);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        x_in  = x;
        a_in  = a;
        if (push) begin
            e.p = p; e.ovf = o; e.name = nm;
            sb_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        x_in  = 8'($urandom);
        a_in  = 4'($urandom);
    endtask

    // Issue, then check that busy is high after E0..E(k+1) and done rises after E(k+2).
    task automatic timed_op(input logic [7:0] x, input logic [3:0] a, input int k,
                            input logic [14:0] p, input logic o, input string nm);
        issue(x, a, 1'b1, p, o, nm);
        for (int i = 0; i <= k + 1; i++) begin
            if (i > 0) @(negedge clk);
            chk({nm, "_busy_run"}, 32'(busy), 32'd1);
            chk({nm, "_done_run"}, 32'(done), 32'd0);
        end
        @(negedge clk);
        chk({nm, "_done_end"}, 32'(done), 32'd1);
        chk({nm, "_busy_end"}, 32'(busy), 32'd0);
    endtask

    task automatic wait_done(input string nm, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL %s_timeout actual done=0 expected done=1 within %0d cycles", nm, budget);
        end
    endtask

    typedef struct {
        logic [7:0]  x;
        logic [3:0]  a;
        int          k;
        logic [14:0] p;
        logic        o;
        string       nm;
    } vec_t;

    vec_t vecs[$] = '{
        '{8'd2,   4'd3,  2, 15'd8,     1'b0, "pow_2_3"},
        '{8'd5,   4'd0,  0, 15'd1,     1'b0, "pow_5_0"},
        '{8'd0,   4'd0,  0, 15'd1,     1'b0, "pow_0_0"},
        '{8'd0,   4'd5,  3, 15'd0,     1'b0, "pow_0_5"},
        '{8'd3,   4'd9,  4, 15'd19683, 1'b0, "pow_3_9"},
        '{8'd2,   4'd15, 4, 15'd0,     1'b1, "pow_2_15"},
        '{8'd255, 4'd2,  2, 15'd32257, 1'b1, "pow_255_2"},
        '{8'd13,  4'd4,  3, 15'd28561, 1'b0, "pow_13_4"},
        '{8'd14,  4'd4,  3, 15'd5648,  1'b1, "pow_14_4"},
        '{8'd1,   4'd15, 4, 15'd1,     1'b0, "pow_1_15"}
    };

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        srst  = 1'b1;
        start = 1'b0;
        x_in  = '0;
        a_in  = '0;
        repeat (3) @(negedge clk);
        srst = 1'b0;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_p_out", 32'(p_out), 32'd0);
`ifdef EXPONENT_OVERFLOW_EN
        chk("reset_overflow", 32'(overflow), 32'd0);
`endif

        foreach (vecs[i]) begin
            timed_op(vecs[i].x, vecs[i].a, vecs[i].k, vecs[i].p, vecs[i].o, vecs[i].nm);
        end

        // Start while busy is ignored; the running 2^3 finishes with 8.
        issue(8'd2, 4'd3, 1'b1, 15'd8, 1'b0, "busy_ignore");
        start = 1'b1;
        x_in  = 8'd7;
        a_in  = 4'd2;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_ignore", 20);

        // A start after done is accepted and clears done at the capture edge.
        issue(8'd7, 4'd2, 1'b1, 15'd49, 1'b0, "pow_7_2");
        chk("restart_done_cleared", 32'(done), 32'd0);
        chk("restart_busy", 32'(busy), 32'd1);
        wait_done("pow_7_2", 20);

        // Reset in the second CALC cycle discards the computation.
        issue(8'd2, 4'd3, 1'b0, 15'd0, 1'b0, "aborted");
        @(negedge clk);
        srst = 1'b1;
        @(negedge clk);
        srst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_p_out", 32'(p_out), 32'd0);
        repeat (6) begin
            @(negedge clk);
            chk("abort_stays_idle", 32'(done | busy), 32'd0);
        end

        // Start sampled together with reset is ignored.
        srst  = 1'b1;
        start = 1'b1;
        x_in  = 8'd3;
        a_in  = 4'd1;
        @(negedge clk);
        srst  = 1'b0;
        start = 1'b0;
        chk("start_with_reset_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("start_with_reset_still_idle", 32'(busy), 32'd0);

        timed_op(8'd2, 4'd3, 2, 15'd8, 1'b0, "after_reset_2_3");

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exponent_core.md
EXPONENT_CORE -- requirements
Module: exponent_core

Interface
- REQ-001: Parameters, one per line (name, default, meaning):
  - X_WIDTH, 8, base operand width.
  - A_WIDTH, 4, exponent operand width.
  - P_WIDTH, 15, result width.
- REQ-002: Ports, one per line (name, direction, width, meaning):
  - S_AXI_ACLK, in, 1, single clock; all logic on rising edge.
  - S_AXI_ARESET, in, 1, reset; synchronous, active-high.
  - start, in, 1, single-cycle request to compute x_in^a_in.
  - x_in, in, X_WIDTH, unsigned base.
  - a_in, in, A_WIDTH, unsigned exponent.
  - busy, out, 1, computation in progress.
  - done, out, 1, result valid; sticky level.
  - p_out, out, P_WIDTH, result x^a mod 2^P_WIDTH.
  - overflow, out, 1, present only with EXPONENT_OVERFLOW_EN (REQ-017).
- REQ-003: The block SHALL use one clock, S_AXI_ACLK, and a synchronous active-high reset, S_AXI_ARESET; the upstream AXI4-Lite register slave drives start, x_in and a_in and reads done and p_out.

Function
- REQ-004: FSM states SHALL be IDLE, CALC and FIN.
- REQ-005: In IDLE, start=1 at edge E0 SHALL capture the following and move to CALC: base<=x_in (zero-extended to P_WIDTH), exp<=a_in, acc<=1, busy<=1, done<=0.
- REQ-006: In CALC with exp!=0, each edge SHALL perform:
  - if exp[0]=1, acc<=(acc*base) mod 2^P_WIDTH;
  - base<=(base*base) mod 2^P_WIDTH;
  - exp<=exp>>1.
- REQ-007: In CALC with exp=0, the edge SHALL load p_out<=acc and move to FIN.
- REQ-008: FIN SHALL last exactly one cycle; its exit edge sets done<=1, busy<=0 and returns to IDLE.
- REQ-009: Latency: with k = bit length of a_in (k=0 when a_in=0), done SHALL rise after edge E(k+2) and busy SHALL be high after edges E0..E(k+1) inclusive.
- REQ-010: done and p_out SHALL hold until the next accepted start or reset; the next accepted start clears done at its capture edge.
- REQ-011: start while busy=1 SHALL be ignored, with no change to operands, state or outputs.
- REQ-012: x^0 SHALL yield 1 for every x, including x=0; 0^a SHALL yield 0 for a>0.
- REQ-013: x_in and a_in SHALL be sampled only at the capture edge; later changes SHALL have no effect on the running computation.
- REQ-014: Multipliers SHALL be P_WIDTH x P_WIDTH; the product is truncated to the low P_WIDTH bits, with no wait states or stalls.

Reset
- REQ-015: S_AXI_ARESET=1 at an edge SHALL force:
  - state IDLE;
  - busy=0, done=0, p_out=0;
  - base=0, exp=0, acc=0;
  - overflow=0 when present.
- REQ-016: Reset SHALL take priority over start and over any in-flight computation, which is discarded; start sampled in the same cycle as reset is ignored.

Configuration
- REQ-017: With macro EXPONENT_OVERFLOW_EN defined, output overflow SHALL exist and behave as follows:
  - cleared at the capture edge;
  - valid with done;
  - 1 iff the true mathematical x^a >= 2^P_WIDTH.
- REQ-018: Overflow SHALL be tracked with an internal base_ovf flag:
  - base_ovf is set when a square truncates;
  - overflow is set when an acc multiply truncates, or when an acc multiply uses base while base_ovf=1.
- REQ-019: Without EXPONENT_OVERFLOW_EN, the overflow port and its logic SHALL be absent; all other behaviour and timing SHALL be identical.

Verification
- REQ-020: x=2, a=3, start at E0 -> busy after E0..E3, done=1 after E4, p_out=8.
- REQ-021: x=5, a=0 -> done after E2, p_out=1; separately x=0, a=0 -> p_out=1; x=0, a=5 -> p_out=0.
- REQ-022: x=3, a=9 -> p_out=19683, overflow=0; x=2, a=15 -> p_out=0, overflow=1; x=255, a=2 -> p_out=65025 mod 32768=32257, overflow=1.
- REQ-023: Second start (x=7, a=2) one cycle after an accepted start (x=2, a=3) -> ignored, final p_out=8; a start after done=1 is accepted, clears done, and gives p_out=49.
- REQ-024: Reset asserted in the second CALC cycle of 2^3 -> busy=0, done=0, p_out=0 the next cycle; a fresh start then completes normally with p_out=8.
- REQ-025: Build without EXPONENT_OVERFLOW_EN -> REQ-020..REQ-024 give identical p_out, done and busy timing.
